// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the register bank: round-robin grant of the single write port,
// registered ALUBus/regEnable drive, and a pending-write scoreboard for hazard detection.
module regbank_wb_arbiter #(
    parameter int NREQ        = 3,
    parameter int DW          = 16,
    parameter int AW          = 4,
    parameter int R0_WRITABLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_dest,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               hold,
    input  logic               set_valid,
    input  logic [AW-1:0]      set_addr,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      ALUBus,
    output logic [15:0]        regEnable,
    output logic [15:0]        busy,
    output logic [15:0]        wb_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   last;
    logic [NREQ-1:0] elig;
    logic            win_vld;
    logic [PW-1:0]   win;
    logic [AW-1:0]   win_dest;
    logic [DW-1:0]   win_data;
    logic [15:0]     win_en;
    logic            fire;
    logic [15:0]     busy_nxt;

    // A requester granted this cycle sits out the next one so it can drop req.
    assign elig = req & ~gnt;

    // Two descending passes: the last hit of each pass is its lowest index, and any
    // hit above the last-grant pointer overrides the wrapped-around group.
    always_comb begin
        win_vld  = 1'b0;
        win      = '0;
        win_dest = '0;
        win_data = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i] && i <= int'(last)) begin
                win_vld  = 1'b1;
                win      = PW'(i);
                win_dest = req_dest[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i] && i > int'(last)) begin
                win_vld  = 1'b1;
                win      = PW'(i);
                win_dest = req_dest[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    assign fire = win_vld && !hold;

    always_comb begin
        win_en = 16'h0001 << win_dest;
        if (R0_WRITABLE == 0 && win_dest == '0)
            win_en = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            ALUBus    <= '0;
            regEnable <= '0;
            wb_count  <= '0;
            last      <= PW'(NREQ - 1);
        end else begin
            gnt       <= '0;
            regEnable <= '0;
            if (fire) begin
                gnt[win]  <= 1'b1;
                ALUBus    <= win_data;
                regEnable <= win_en;
                wb_count  <= wb_count + 16'd1;
                last      <= win;
            end
        end
    end

    // Set is applied after clear: a newer write to the same register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (fire)
            busy_nxt[win_dest] = 1'b0;
        if (set_valid)
            busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: one instance with r0 writable, one with r0 protected.
module tb_regbank_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [2:0]  req_a, gnt_a, req_b, gnt_b;
    logic [11:0] dest_a, dest_b;
    logic [47:0] data_a, data_b;
    logic        hold_a, hold_b, sv_a, sv_b;
    logic [3:0]  sa_a, sa_b;
    logic [15:0] bus_a, en_a, busy_a, cnt_a;
    logic [15:0] bus_b, en_b, busy_b, cnt_b;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    regbank_wb_arbiter #(.NREQ(3), .DW(16), .AW(4), .R0_WRITABLE(1)) dut (
        .clk(clk), .reset(reset), .req(req_a), .req_dest(dest_a), .req_data(data_a),
        .hold(hold_a), .set_valid(sv_a), .set_addr(sa_a), .gnt(gnt_a), .ALUBus(bus_a),
        .regEnable(en_a), .busy(busy_a), .wb_count(cnt_a)
    );

    regbank_wb_arbiter #(.NREQ(3), .DW(16), .AW(4), .R0_WRITABLE(0)) dut_r0 (
        .clk(clk), .reset(reset), .req(req_b), .req_dest(dest_b), .req_data(data_b),
        .hold(hold_b), .set_valid(sv_b), .set_addr(sa_b), .gnt(gnt_b), .ALUBus(bus_b),
        .regEnable(en_b), .busy(busy_b), .wb_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_a = '0; dest_a = '0; data_a = '0; hold_a = 1'b0; sv_a = 1'b0; sa_a = '0;
        req_b = '0; dest_b = '0; data_b = '0; hold_b = 1'b0; sv_b = 1'b0; sb_init();
        #2;
        chk("rst_gnt", 32'(gnt_a), 32'h0);
        chk("rst_en", 32'(en_a), 32'h0);
        chk("rst_bus", 32'(bus_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_cnt", 32'(cnt_a), 32'h0);
        #10 reset = 1'b0;
        tick();

        // single requester
        req_a = 3'b001; dest_a = {4'd0, 4'd0, 4'd5}; data_a = {16'h0, 16'h0, 16'hBEEF};
        tick();
        chk("single_gnt", 32'(gnt_a), 32'h1);
        chk("single_en", 32'(en_a), 32'h0020);
        chk("single_bus", 32'(bus_a), 32'hBEEF);
        chk("single_cnt", 32'(cnt_a), 32'h1);

        // async reset mid-cycle while gnt=001
        #2 reset = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt_a), 32'h0);
        chk("arst_en", 32'(en_a), 32'h0);
        chk("arst_bus", 32'(bus_a), 32'h0);
        chk("arst_cnt", 32'(cnt_a), 32'h0);
        req_a = 3'b111; dest_a = {4'd3, 4'd2, 4'd1}; data_a = {16'hC222, 16'hB111, 16'hA000};
        tick();
        chk("arst_hold_gnt", 32'(gnt_a), 32'h0);
        #2 reset = 1'b0;

        // round robin, requester 0 first after reset
        tick();
        chk("rr0_gnt", 32'(gnt_a), 32'h1);
        chk("rr0_en", 32'(en_a), 32'h0002);
        chk("rr0_bus", 32'(bus_a), 32'hA000);
        tick();
        chk("rr1_gnt", 32'(gnt_a), 32'h2);
        chk("rr1_en", 32'(en_a), 32'h0004);
        chk("rr1_bus", 32'(bus_a), 32'hB111);
        tick();
        chk("rr2_gnt", 32'(gnt_a), 32'h4);
        chk("rr2_en", 32'(en_a), 32'h0008);
        tick();
        chk("rr3_gnt", 32'(gnt_a), 32'h1);
        chk("rr3_en", 32'(en_a), 32'h0002);
        chk("rr_cnt", 32'(cnt_a), 32'h4);
        req_a = '0;
        tick();
        chk("idle_gnt", 32'(gnt_a), 32'h0);
        chk("idle_bus", 32'(bus_a), 32'hA000);

        // hold blocks grants, request stays pending
        req_a = 3'b010; hold_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_gnt", 32'(gnt_a), 32'h0);
            chk("hold_en", 32'(en_a), 32'h0);
        end
        hold_a = 1'b0;
        tick();
        chk("unhold_gnt", 32'(gnt_a), 32'h2);
        chk("unhold_en", 32'(en_a), 32'h0004);
        req_a = '0;
        tick();
        chk("unhold_gnt2", 32'(gnt_a), 32'h0);
        chk("unhold_cnt", 32'(cnt_a), 32'h5);

        // scoreboard
        sv_a = 1'b1; sa_a = 4'd7;
        tick();
        chk("sb_set", 32'(busy_a), 32'h0080);
        req_a = 3'b001; dest_a = {4'd3, 4'd2, 4'd7}; data_a = {16'hC222, 16'hB111, 16'h7777};
        tick();
        chk("sb_same_gnt", 32'(gnt_a), 32'h1);
        chk("sb_same_busy", 32'(busy_a), 32'h0080);
        sv_a = 1'b0;
        tick();
        chk("sb_gap_gnt", 32'(gnt_a), 32'h0);
        tick();
        chk("sb_clr_gnt", 32'(gnt_a), 32'h1);
        chk("sb_clr_busy", 32'(busy_a), 32'h0000);
        req_a = '0;

        // r0 protection on the second instance
        sv_b = 1'b1; sa_b = 4'd0;
        tick();
        chk("r0_busy_set", 32'(busy_b), 32'h0001);
        sv_b = 1'b0;
        req_b = 3'b001; dest_b = {4'd0, 4'd0, 4'd0}; data_b = {16'h0, 16'h0, 16'h1234};
        tick();
        chk("r0_gnt", 32'(gnt_b), 32'h1);
        chk("r0_en", 32'(en_b), 32'h0000);
        chk("r0_bus", 32'(bus_b), 32'h1234);
        chk("r0_cnt", 32'(cnt_b), 32'h1);
        chk("r0_busy_clr", 32'(busy_b), 32'h0000);
        req_b = '0;
        tick();
        req_b = 3'b001; dest_b = {4'd0, 4'd0, 4'd3}; data_b = {16'h0, 16'h0, 16'h5678};
        tick();
        chk("r0_other_en", 32'(en_b), 32'h0008);
        chk("r0_other_cnt", 32'(cnt_b), 32'h2);

        // two requesters alternate, one grant per cycle, up to the counter wrap
        req_b = 3'b011; dest_b = {4'd0, 4'd1, 4'd0};
        exp_cnt = 16'd2;
        while (exp_cnt != 16'hFFFF) begin
            tick();
            exp_cnt = exp_cnt + 16'd1;
        end
        chk("cnt_max", 32'(cnt_b), 32'hFFFF);
        tick();
        chk("cnt_wrap", 32'(cnt_b), 32'h0000);
        req_b = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic sb_init();
        sa_b = '0;
    endtask

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port (ALUBus data plus 16-bit one-hot regEnable) among NREQ write-back requesters: ALU result, memory load, link/PC.
- Round-robin arbitration grants one write per cycle and drives registered bus data and a one-hot enable into RegBank.
- Keeps a pending-write scoreboard (busy bits) so the decode stage can detect read-after-write hazards.
- Sits between the execute/memory stages and RegBank.

Parameters:
NREQ, 3, number of write-back requesters (2..4)
DW, 16, data width, matches ALUBus
AW, 4, register address width (16 registers)
R0_WRITABLE, 1, 0 = writes to r0 are acknowledged but dropped

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req  in  NREQ  write request per requester, held until granted
req_dest  in  NREQ*AW  destination register per requester; requester i uses slice [i*AW +: AW]
req_data  in  NREQ*DW  write data per requester; slice [i*DW +: DW]
hold  in  1  stall: no new grants while high
set_valid  in  1  issue stage marks a register as pending
set_addr  in  AW  register to mark pending
gnt  out  NREQ  one-hot, one-cycle grant pulse
ALUBus  out  DW  registered write data to RegBank
regEnable  out  16  registered one-hot write enable to RegBank
busy  out  16  scoreboard, bit n = write to rn pending
wb_count  out  16  committed-write counter, wraps at 0xFFFF->0

Behaviour:
- Reset (async, immediate):
  - gnt=0, ALUBus=0, regEnable=0, busy=0, wb_count=0.
  - last-grant pointer = NREQ-1, so requester 0 has first priority.
- Eligibility: requester i is eligible in a cycle if req[i]=1 and gnt[i]=0 in that cycle. A requester is never granted on consecutive cycles, which gives it one cycle to drop req after seeing gnt.
- Arbitration (combinational, evaluated every cycle): search eligible requesters starting at (last+1) mod NREQ, wrapping; the first hit wins.
- At the rising edge, if a winner w exists and hold=0:
  - gnt <= one-hot(w); ALUBus <= req_data[w]; last <= w.
  - regEnable <= one-hot(req_dest[w]), or all zeros if R0_WRITABLE=0 and req_dest[w]=0.
  - wb_count <= wb_count+1, counted even when an r0 write is dropped.
- Otherwise at the rising edge: gnt <= 0, regEnable <= 0, ALUBus holds its last value, last unchanged.
- Latency:
  - Request present before edge E0 -> gnt/regEnable high during the cycle after E0.
  - RegBank captures the data at edge E1, one cycle after E0.
  - Worst-case wait for a requester: NREQ-1 grants.
- hold:
  - Sampled at the edge. Blocks new grants only.
  - An in-flight regEnable (already registered) still completes.
  - Requests stay pending and are not lost.
- Scoreboard:
  - Clear: at an edge where a grant is issued, busy[req_dest[w]] <= 0. This applies to dropped r0 writes too.
  - Set: set_valid=1 sets busy[set_addr] <= 1.
  - Same register set and cleared on the same edge: the set wins, because a newer write is pending.
  - Set for an already-busy register: no change.
  - busy is not checked against grants; a grant to a non-busy register is legal.
- Requester protocol:
  - req_dest and req_data must be stable from req assertion until gnt.
  - A requester dropping req before gnt withdraws its request with no side effects.
- Invariants: at most one gnt bit high; regEnable is one-hot or zero; regEnable nonzero implies gnt nonzero.
- Reset mid-operation: a pending grant/regEnable is cancelled immediately and no write occurs at the next edge.

Test Plan:
- Reset sequence: assert reset mid-cycle while gnt=001 -> outputs go to 0 asynchronously; after release, req=111 -> first grant is requester 0.
- Single requester: req=001, dest=5, data=0xBEEF -> next cycle gnt=001, regEnable=0x0020, ALUBus=0xBEEF. The following cycle gnt=000 even though req is still high; wb_count=1.
- Round-robin: req=111 held continuously, dests 1/2/3 -> grants 001,010,100,001 on consecutive cycles; regEnable 0x0002,0x0004,0x0008.
- hold: req=010 with hold=1 for 3 cycles -> gnt=0 and regEnable=0 throughout. Drop hold -> gnt=010 next cycle; wb_count increments exactly once.
- Scoreboard: set_valid with set_addr=7 -> busy=0x0080. Grant to dest 7 while set_valid with set_addr=7 on the same edge -> busy stays 0x0080. Next grant to dest 7 -> busy=0x0000.
- R0 protection (R0_WRITABLE=0): req=001, dest=0, data=0x1234 -> gnt=001, regEnable=0x0000, wb_count increments, busy[0] cleared. wb_count preset near 0xFFFF wraps to 0x0000.
